// File: rtl/video_in_to_axis_if.sv
// AXI-Stream video bus: one beat per pixel, tuser = start of frame, tlast = end of frame.
interface video_in_to_axis_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/video_in_to_axis.sv
// Raw parallel video (de/vsync/data) to frame-delimited AXI-Stream through a small FWFT FIFO.
// Aborted frames are always closed with a data=0, tlast=1 terminator beat.
module video_in_to_axis #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int ACTIVE_W   = 640,
    parameter int ACTIVE_H   = 480,
    parameter bit VSYNC_POL  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr_status,
    input  logic                  vid_de,
    input  logic                  vid_vsync,
    input  logic [DATA_WIDTH-1:0] vid_data,
    video_in_to_axis_if.master    m_axis,
    output logic                  overflow,
    output logic                  size_err,
    output logic [15:0]           frame_cnt
);
    localparam int XW = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
    localparam int YW = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_LAST = XW'(ACTIVE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ACTIVE_H - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, TERM, DROP} state_t;

    typedef struct packed {
        logic                  tuser;
        logic                  tlast;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          vsync_q;
    logic          fs_pending;
    logic          fs;

    beat_t         mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    beat_t         push_beat;
    beat_t         head;

    logic          first_px;
    logic          last_px;
    logic          ovf_set;
    logic          size_set;

    assign fs       = (vid_vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && m_axis.tready;
    assign first_px = (x == '0) && (y == '0);
    assign last_px  = (x == X_LAST) && (y == Y_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push      = 1'b0;
        push_beat = '0;
        ovf_set   = 1'b0;
        size_set  = 1'b0;
        case (state)
            ACTIVE: begin
                if (fs) begin
                    size_set = 1'b1;
                end else if (vid_de) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_beat = '{tuser: first_px, tlast: last_px, data: vid_data};
                    end
                end
            end
            TERM: begin
                if (!full) begin
                    push      = 1'b1;
                    push_beat = '{tuser: 1'b0, tlast: 1'b1, data: '0};
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            vsync_q    <= ~VSYNC_POL;
            fs_pending <= 1'b0;
            overflow   <= 1'b0;
            size_err   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_q  <= vid_vsync;
            overflow <= (overflow && !clr_status) || ovf_set;
            size_err <= (size_err && !clr_status) || size_set;
            case (state)
                IDLE: begin
                    if (fs && enable) begin
                        state <= ACTIVE;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ACTIVE: begin
                    // The fs that aborts a frame is consumed here; its frame is not captured.
                    if (fs || (vid_de && full)) begin
                        state      <= TERM;
                        fs_pending <= 1'b0;
                    end else if (vid_de) begin
                        if (last_px) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else if (x == X_LAST) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                TERM: begin
                    if (fs) fs_pending <= 1'b1;
                    if (!full) state <= DROP;
                end
                DROP: begin
                    if (fs || fs_pending) begin
                        fs_pending <= 1'b0;
                        if (enable) begin
                            state <= ACTIVE;
                            x     <= '0;
                            y     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage has no reset; an entry is only visible after it has been written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_beat;
    end

    assign head          = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = head.data;
    assign m_axis.tuser  = head.tuser;
    assign m_axis.tlast  = head.tlast;
endmodule

// File: tb/tb_video_in_to_axis.sv
// Bench for video_in_to_axis: queue-based reference model compared every cycle, plus directed frame scenarios.
module tb_video_in_to_axis;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int W     = 4;
    localparam int H     = 2;
    localparam bit POL   = 1'b1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clr_status;
    logic          vid_de;
    logic          vid_vsync;
    logic [DW-1:0] vid_data;
    logic          overflow;
    logic          size_err;
    logic [15:0]   frame_cnt;

    video_in_to_axis_if #(.DATA_WIDTH(DW)) axis ();

    video_in_to_axis #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ACTIVE_W(W), .ACTIVE_H(H), .VSYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status),
        .vid_de(vid_de), .vid_vsync(vid_vsync), .vid_data(vid_data),
        .m_axis(axis),
        .overflow(overflow), .size_err(size_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit toggle_rdy = 1'b0;
    logic [DW+1:0] got [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a run of W*H pixel indices; aborted runs owe one terminator.
    logic [DW+1:0] mq [$];
    bit m_cap, m_term, m_wait, m_pend, m_ovf, m_size, m_vs_prev;
    int m_idx, m_frames;

    always @(posedge clk) begin : model_p
        bit fs, full, do_pop, do_push, ovf_hit, size_hit;
        logic [DW+1:0] beat;
        if (rst) begin
            mq.delete();
            m_cap = 0; m_term = 0; m_wait = 0; m_pend = 0;
            m_ovf = 0; m_size = 0; m_vs_prev = !POL;
            m_idx = 0; m_frames = 0;
        end else begin
            fs        = (vid_vsync == POL) && (m_vs_prev != POL);
            m_vs_prev = vid_vsync;
            full      = (mq.size() >= DEPTH);
            do_pop    = (mq.size() > 0) && axis.tready;
            do_push   = 0; ovf_hit = 0; size_hit = 0; beat = '0;
            if (m_cap) begin
                if (fs) begin
                    size_hit = 1; m_cap = 0; m_term = 1; m_pend = 0;
                end else if (vid_de) begin
                    if (full) begin
                        ovf_hit = 1; m_cap = 0; m_term = 1; m_pend = 0;
                    end else begin
                        do_push = 1;
                        beat = {m_idx == 0, m_idx == W*H-1, vid_data};
                        m_idx++;
                        if (m_idx == W*H) begin
                            m_cap = 0;
                            m_frames++;
                        end
                    end
                end
            end else if (m_term) begin
                if (fs) m_pend = 1;
                if (!full) begin
                    do_push = 1; beat = {1'b0, 1'b1, {DW{1'b0}}};
                    m_term = 0; m_wait = 1;
                end
            end else if (m_wait) begin
                if (fs || m_pend) begin
                    m_wait = 0; m_pend = 0;
                    if (enable) begin m_cap = 1; m_idx = 0; end
                end
            end else if (fs && enable) begin
                m_cap = 1; m_idx = 0;
            end
            m_ovf  = (m_ovf && !clr_status) || ovf_hit;
            m_size = (m_size && !clr_status) || size_hit;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(beat);
        end
    end

    always @(negedge clk) begin
        check("tvalid", axis.tvalid, mq.size() != 0);
        if (mq.size() != 0) check("head_beat", {axis.tuser, axis.tlast, axis.tdata}, mq[0]);
        check("overflow", overflow, m_ovf);
        check("size_err", size_err, m_size);
        check("frame_cnt", frame_cnt, 16'(m_frames));
        if (!rst && axis.tvalid && axis.tready) got.push_back({axis.tuser, axis.tlast, axis.tdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) axis.tready = ~axis.tready;
    endtask

    task automatic send_fs();
        vid_vsync = 1'b1;
        tick();
        vid_vsync = 1'b0;
    endtask

    task automatic send_pixels(input int base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            vid_de   = 1'b1;
            vid_data = DW'(base + i);
            tick();
            vid_de = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        toggle_rdy  = 1'b0;
        axis.tready = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            tick();
            if (mq.size() == 0 && !axis.tvalid) done = 1'b1;
        end
        check("drain_done", done, 1);
    endtask

    task automatic expect_beat(input string name, input int i, input bit u, input bit l, input int data);
        logic [DW+1:0] b = '1;
        if (i < got.size()) b = got[i];
        check(name, b, {u, l, DW'(data)});
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; clr_status = 1'b0;
        vid_de = 1'b0; vid_vsync = 1'b0; vid_data = '0; axis.tready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Normal frame, tready high
        axis.tready = 1'b1;
        send_fs();
        send_pixels(1, 8, 0);
        drain();
        check("t1_count", got.size(), 8);
        for (int i = 0; i < 8; i++) expect_beat("t1_beat", i, i == 0, i == 7, i + 1);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_overflow", overflow, 0);
        got.delete();

        // Overflow with tready low; clr_status coincides with the overflow set
        axis.tready = 1'b0;
        send_fs();
        send_pixels(1, 4, 0);
        clr_status = 1'b1;
        vid_de = 1'b1; vid_data = DW'(5);
        tick();
        clr_status = 1'b0; vid_de = 1'b0;
        send_pixels(6, 3, 0);
        tick();
        check("t2_overflow", overflow, 1);
        check("t2_stalled_valid", axis.tvalid, 1);
        drain();
        check("t2_count", got.size(), 5);
        for (int i = 0; i < 4; i++) expect_beat("t2_beat", i, i == 0, 1'b0, i + 1);
        expect_beat("t2_term", 4, 1'b0, 1'b1, 0);
        check("t2_frame_cnt", frame_cnt, 1);
        pulse_clr();
        check("t2_ovf_cleared", overflow, 0);
        got.delete();

        // Short frame, uncaptured frame, then a normal frame
        send_fs();
        send_pixels(1, 5, 0);
        send_fs();
        send_pixels('h101, 8, 0);
        send_fs();
        send_pixels('h201, 8, 0);
        drain();
        check("t3_size_err", size_err, 1);
        check("t3_frame_cnt", frame_cnt, 2);
        check("t3_count", got.size(), 14);
        for (int i = 0; i < 5; i++) expect_beat("t3_short", i, i == 0, 1'b0, i + 1);
        expect_beat("t3_term", 5, 1'b0, 1'b1, 0);
        for (int i = 0; i < 8; i++) expect_beat("t3_full", 6 + i, i == 0, i == 7, 'h201 + i);
        pulse_clr();
        check("t3_size_cleared", size_err, 0);
        got.delete();

        // enable low at fs; enable dropped mid-frame; next fs ignored
        enable = 1'b0;
        send_fs();
        send_pixels('h301, 8, 0);
        drain();
        check("t4_disabled_count", got.size(), 0);
        enable = 1'b1;
        send_fs();
        send_pixels('h401, 3, 0);
        enable = 1'b0;
        send_pixels('h404, 5, 0);
        send_fs();
        send_pixels('h501, 8, 0);
        drain();
        check("t4_count", got.size(), 8);
        for (int i = 0; i < 8; i++) expect_beat("t4_beat", i, i == 0, i == 7, 'h401 + i);
        check("t4_frame_cnt", frame_cnt, 3);
        got.delete();

        // tready toggling every cycle, pixels every third cycle
        enable = 1'b1;
        axis.tready = 1'b1;
        toggle_rdy = 1'b1;
        send_fs();
        send_pixels('h601, 8, 2);
        drain();
        check("t5_count", got.size(), 8);
        for (int i = 0; i < 8; i++) expect_beat("t5_beat", i, i == 0, i == 7, 'h601 + i);
        check("t5_frame_cnt", frame_cnt, 4);
        check("t5_overflow", overflow, 0);
        got.delete();

        // Reset mid-frame with beats queued
        axis.tready = 1'b0;
        send_fs();
        send_pixels('h701, 3, 0);
        tick();
        check("t6_queued_valid", axis.tvalid, 1);
        rst = 1'b1;
        tick();
        check("t6_rst_tvalid", axis.tvalid, 0);
        check("t6_rst_frame_cnt", frame_cnt, 0);
        check("t6_rst_flags", {overflow, size_err}, 0);
        rst = 1'b0;
        tick();
        got.delete();
        axis.tready = 1'b1;
        send_fs();
        send_pixels('h801, 8, 0);
        drain();
        check("t6_count", got.size(), 8);
        for (int i = 0; i < 8; i++) expect_beat("t6_beat", i, i == 0, i == 7, 'h801 + i);
        check("t6_frame_cnt", frame_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
